usb_dfifo_arbiter: RTL and testbench

- Shares the single-port DFIFO RAM (2048 x 35, read latency 1) between three requesters: the USB OTG controller, a debug read/write port on the AXI side, and an internal zero-fill scrub engine.
- The controller has absolute, zero-latency priority because it cannot stall.
- Scrub and debug use only cycles in which the controller leaves the RAM idle.
- Sits between the controller's active-low DFIFO pins and the RAM primitive, in the aclk domain.

---
 rtl/usb_dfifo_pkg.sv | 22 ++
 rtl/usb_dfifo_arbiter_if.sv | 40 ++++
 rtl/usb_dfifo_scrub.sv | 65 ++++++
 rtl/usb_dfifo_arbiter.sv | 102 ++++++++++
 tb/tb_usb_dfifo_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_dfifo_pkg.sv
// Shared types and default geometry for the DFIFO RAM arbiter.
package usb_dfifo_pkg;

  localparam int DFIFO_ADDR_W = 11;
  localparam int DFIFO_DATA_W = 35;
  localparam int DFIFO_DEPTH  = 2048;

  typedef enum logic [1:0] {
    SCRUB_IDLE = 2'd0,
    SCRUB_RUN  = 2'd1,
    SCRUB_DONE = 2'd2
  } scrub_state_e;

  // One requester's view of a RAM access; the arbiter picks one per cycle.
  typedef struct packed {
    logic                    en;
    logic                    we;
    logic [DFIFO_ADDR_W-1:0] addr;
    logic [DFIFO_DATA_W-1:0] wdata;
  } dfifo_req_t;

endpackage

// File: rtl/usb_dfifo_arbiter_if.sv
// Bus bundle between the environment (controller pins, RAM, debug port)
// and the DFIFO arbiter. The arbiter connects through the slave modport.
interface usb_dfifo_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 35
);
  logic              ctl_ce_n;
  logic              ctl_wr_n;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic [DATA_W-1:0] ctl_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  modport slave (
    input  ctl_ce_n, ctl_wr_n, ctl_addr, ctl_wdata, ram_dout,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output ctl_rdata, ram_en, ram_we, ram_addr, ram_din,
           dbg_gnt, dbg_rvalid, dbg_rdata
  );

  modport master (
    output ctl_ce_n, ctl_wr_n, ctl_addr, ctl_wdata, ram_dout,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  ctl_rdata, ram_en, ram_we, ram_addr, ram_din,
           dbg_gnt, dbg_rvalid, dbg_rdata
  );
endinterface

// File: rtl/usb_dfifo_scrub.sv
// Zero-fill engine: walks every DFIFO address once, writing zero, and only
// advances in cycles the controller leaves the RAM idle.
module usb_dfifo_scrub
  import usb_dfifo_pkg::*;
#(
  parameter int DEPTH = DFIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       idle_slot,
  output dfifo_req_t req,
  output logic       busy,
  output logic       done
);

  localparam logic [DFIFO_ADDR_W-1:0] LAST_ADDR = DFIFO_ADDR_W'(DEPTH - 1);

  scrub_state_e            state_q, state_d;
  logic [DFIFO_ADDR_W-1:0] addr_q, addr_d;

  // State and address registers; reset abandons any scrub in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCRUB_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state, address advance and the write request for the arbiter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req     = '0;
    case (state_q)
      SCRUB_IDLE: begin
        if (start) begin
          state_d = SCRUB_RUN;
          addr_d  = '0;
        end
      end
      SCRUB_RUN: begin
        req.en   = idle_slot;
        req.we   = idle_slot;
        req.addr = addr_q;
        if (idle_slot) begin
          if (addr_q == LAST_ADDR) begin
            state_d = SCRUB_DONE;
          end else begin
            addr_d = addr_q + DFIFO_ADDR_W'(1);
          end
        end
      end
      SCRUB_DONE: state_d = SCRUB_IDLE;
      default:    state_d = SCRUB_IDLE;
    endcase
  end

  assign busy = (state_q == SCRUB_RUN);
  assign done = (state_q == SCRUB_DONE);

endmodule

// File: rtl/usb_dfifo_arbiter.sv
// Shares the single-port DFIFO RAM between the USB controller (absolute
// priority), the zero-fill scrubber and the debug port.
module usb_dfifo_arbiter
  import usb_dfifo_pkg::*;
#(
  parameter int ADDR_W = DFIFO_ADDR_W,
  parameter int DATA_W = DFIFO_DATA_W,
  parameter int DEPTH  = DFIFO_DEPTH,
  parameter int WAIT_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  usb_dfifo_arbiter_if.slave bus,
  input  logic              scrub_start,
  output logic              scrub_busy,
  output logic              scrub_done,
  output logic [WAIT_W-1:0] dbg_wait_max
);

  dfifo_req_t        scrub_req;
  dfifo_req_t        ram_req;
  logic              dbg_gnt;
  logic              rd_pend_q, rd_pend_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_max_q, wait_max_d;

  usb_dfifo_scrub #(.DEPTH(DEPTH)) u_scrub (
    .clk       (aclk),
    .rst       (areset),
    .start     (scrub_start),
    .idle_slot (bus.ctl_ce_n),
    .req       (scrub_req),
    .busy      (scrub_busy),
    .done      (scrub_done)
  );

  // Fixed-priority RAM mux: controller, then scrubber, then debug; reset parks the RAM.
  always_comb begin
    dbg_gnt = bus.dbg_req & bus.ctl_ce_n & ~scrub_busy & ~areset;
    ram_req = '0;
    if (!areset) begin
      if (!bus.ctl_ce_n) begin
        ram_req.en    = 1'b1;
        ram_req.we    = ~bus.ctl_wr_n;
        ram_req.addr  = DFIFO_ADDR_W'(bus.ctl_addr);
        ram_req.wdata = DFIFO_DATA_W'(bus.ctl_wdata);
      end else if (scrub_req.en) begin
        ram_req = scrub_req;
      end else if (dbg_gnt) begin
        ram_req.en    = 1'b1;
        ram_req.we    = bus.dbg_we;
        ram_req.addr  = DFIFO_ADDR_W'(bus.dbg_addr);
        ram_req.wdata = DFIFO_DATA_W'(bus.dbg_wdata);
      end
    end
  end

  assign bus.ram_en    = ram_req.en;
  assign bus.ram_we    = ram_req.we;
  assign bus.ram_addr  = ADDR_W'(ram_req.addr);
  assign bus.ram_din   = DATA_W'(ram_req.wdata);
  assign bus.ctl_rdata = bus.ram_dout;
  assign bus.dbg_gnt   = dbg_gnt;

  // Debug read return pipeline and the grant-wait statistics.
  always_comb begin
    rd_pend_d = dbg_gnt & ~bus.dbg_we;
    rvalid_d  = rd_pend_q;
    rdata_d   = rd_pend_q ? bus.ram_dout : rdata_q;
    wait_cnt_d = wait_cnt_q;
    if (dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (bus.dbg_req && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    wait_max_d = (wait_cnt_q > wait_max_q) ? wait_cnt_q : wait_max_q;
  end

  // Debug-side registers; reset drops any read still in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_pend_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      wait_max_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      wait_max_q <= wait_max_d;
    end
  end

  assign bus.dbg_rvalid = rvalid_q & ~areset;
  assign bus.dbg_rdata  = rdata_q;
  assign dbg_wait_max   = wait_max_q;

endmodule

// File: tb/tb_usb_dfifo_arbiter.sv
// Scoreboard bench for usb_dfifo_arbiter with a behavioural 1-cycle RAM.
module tb_usb_dfifo_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 35;
  localparam int DEPTH = 2048;
  localparam int WW    = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            at;
  } dexp_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          scrub_start;
  logic          scrub_busy;
  logic          scrub_done;
  logic [WW-1:0] dbg_wait_max;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          ctl_rd_last = 1'b0;
  dexp_t         dbg_q[$];
  logic [DW-1:0] ctl_q[$];
  int            done_q[$];
  logic [DW-1:0] mem [DEPTH];

  usb_dfifo_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  usb_dfifo_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_W(WW)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .bus          (bus.slave),
    .scrub_start  (scrub_start),
    .scrub_busy   (scrub_busy),
    .scrub_done   (scrub_done),
    .dbg_wait_max (dbg_wait_max)
  );

  always #5 aclk = ~aclk;

  // Behavioural RAM, preloaded with a nonzero pattern so zero-fill is visible.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(32'hDEAD_0000) | DW'(i);
  end

  always @(posedge aclk) begin
    if (bus.ram_en === 1'b1) begin
      if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
      else bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  // Cycle counter and a record of whether the controller read last cycle.
  always @(posedge aclk) begin
    cyc         <= cyc + 1;
    ctl_rd_last <= ~bus.ctl_ce_n & bus.ctl_wr_n & ~areset;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge aclk) begin
    dexp_t e;
    if (bus.dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL dbg_rvalid_unexpected: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = dbg_q.pop_front();
        checkOutput("dbg_rdata", 64'(bus.dbg_rdata), 64'(e.data));
        checkOutput("dbg_rvalid_cycle", 64'(cyc), 64'(e.at));
      end
    end
    if (ctl_rd_last) begin
      if (ctl_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL ctl_read_unexpected: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        checkOutput("ctl_rdata", 64'(bus.ctl_rdata), 64'(ctl_q.pop_front()));
      end
    end
    if (scrub_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL scrub_done_unexpected: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        checkOutput("scrub_done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
    if (scrub_busy === 1'b1 && bus.dbg_req === 1'b1) begin
      checkOutput("dbg_gnt_while_busy", 64'(bus.dbg_gnt), 64'd0);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic ce_n, input logic wr_n, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, input logic dreq, input logic dwe,
                               input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                               input logic sstart);
    bus.ctl_ce_n  = ce_n;
    bus.ctl_wr_n  = wr_n;
    bus.ctl_addr  = addr;
    bus.ctl_wdata = wd;
    bus.dbg_req   = dreq;
    bus.dbg_we    = dwe;
    bus.dbg_addr  = daddr;
    bus.dbg_wdata = dwd;
    scrub_start   = sstart;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic ctlWrite(input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    applyStimulus(1'b0, 1'b0, addr, wd, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic ctlRead(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    applyStimulus(1'b0, 1'b1, addr, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    ctl_q.push_back(exp);
  endtask

  task automatic dbgRead(input logic [AW-1:0] addr, input logic sstart);
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, 1'b0, addr, '0, sstart);
  endtask

  task automatic pushDbg(input logic [DW-1:0] data, input int at);
    dexp_t e;
    e.data = data;
    e.at   = at;
    dbg_q.push_back(e);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish at cycle %0d", cyc);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    int  s, g, m, n;
    bit  got;

    // Reset with controller and debug both demanding the RAM.
    areset = 1'b1;
    idleInputs();
    bus.ctl_ce_n = 1'b0;
    bus.ctl_wr_n = 1'b0;
    bus.dbg_req  = 1'b1;
    tick(); tick();
    @(negedge aclk);
    checkOutput("rst_ram_en", 64'(bus.ram_en), 64'd0);
    checkOutput("rst_ram_we", 64'(bus.ram_we), 64'd0);
    checkOutput("rst_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
    checkOutput("rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    checkOutput("rst_dbg_rdata", 64'(bus.dbg_rdata), 64'd0);
    checkOutput("rst_scrub_busy", 64'(scrub_busy), 64'd0);
    checkOutput("rst_scrub_done", 64'(scrub_done), 64'd0);
    checkOutput("rst_wait_max", 64'(dbg_wait_max), 64'd0);
    tick();
    areset = 1'b0;
    idleInputs();
    tick();

    // Controller-only traffic.
    ctlWrite(11'h010, 35'h1_2345_6789);
    @(negedge aclk);
    checkOutput("ctl_wr_ram_en", 64'(bus.ram_en), 64'd1);
    checkOutput("ctl_wr_ram_we", 64'(bus.ram_we), 64'd1);
    checkOutput("ctl_wr_ram_addr", 64'(bus.ram_addr), 64'h010);
    checkOutput("ctl_wr_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
    tick();
    ctlRead(11'h010, 35'h1_2345_6789);
    @(negedge aclk);
    checkOutput("ctl_rd_ram_we", 64'(bus.ram_we), 64'd0);
    tick();
    ctlWrite(11'h011, 35'h4_AAAA_5555);
    tick();
    idleInputs();
    tick();

    // Single debug read, then two back to back.
    dbgRead(11'h010, 1'b0);
    @(negedge aclk);
    checkOutput("dbg_rd_gnt", 64'(bus.dbg_gnt), 64'd1);
    pushDbg(35'h1_2345_6789, cyc + 2);
    tick();
    idleInputs();
    tick();
    dbgRead(11'h010, 1'b0);
    pushDbg(35'h1_2345_6789, cyc + 2);
    tick();
    dbgRead(11'h011, 1'b0);
    pushDbg(35'h4_AAAA_5555, cyc + 2);
    tick();
    idleInputs();
    tick(); tick(); tick();

    // Debug write held off by ten controller cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, AW'(11'h100 + i), DW'(i), 1'b1, 1'b1, 11'h030, 35'h5_DEAD_BEEF, 1'b0);
      @(negedge aclk);
      checkOutput("contended_gnt", 64'(bus.dbg_gnt), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 11'h030, 35'h5_DEAD_BEEF, 1'b0);
    @(negedge aclk);
    checkOutput("contended_gnt_11", 64'(bus.dbg_gnt), 64'd1);
    checkOutput("contended_ram_din", 64'(bus.ram_din), 64'h5_DEAD_BEEF);
    tick();
    idleInputs();
    @(negedge aclk);
    checkOutput("wait_max_10", 64'(dbg_wait_max), 64'd10);
    tick();
    ctlRead(11'h030, 35'h5_DEAD_BEEF);
    tick();
    idleInputs();
    tick();

    // Wait counter saturation: twenty blocked cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, AW'(11'h200 + i), DW'(i), 1'b1, 1'b0, 11'h010, '0, 1'b0);
      tick();
    end
    dbgRead(11'h010, 1'b0);
    pushDbg(35'h1_2345_6789, cyc + 2);
    tick();
    idleInputs();
    @(negedge aclk);
    checkOutput("wait_max_sat", 64'(dbg_wait_max), 64'd15);
    tick(); tick(); tick();

    // Full scrub with a 100-cycle controller burst and a blocked debug read.
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    s = cyc;
    done_q.push_back(s + 1 + DEPTH + 100);
    tick();
    idleInputs();
    @(negedge aclk);
    checkOutput("scrub_first_addr", 64'(bus.ram_addr), 64'd0);
    checkOutput("scrub_first_we", 64'(bus.ram_we), 64'd1);
    checkOutput("scrub_busy_run", 64'(scrub_busy), 64'd1);
    tick();
    for (int i = 0; i < 300; i++) begin
      idleInputs();
      if (i == 150) scrub_start = 1'b1;
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      ctlRead(11'h005, '0);
      tick();
    end
    got = 1'b0;
    g   = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      dbgRead(11'h7FF, 1'b0);
      @(negedge aclk);
      if (bus.dbg_gnt === 1'b1) begin
        got = 1'b1;
        g   = cyc;
      end else begin
        tick();
      end
    end
    checkOutput("scrub_dbg_gnt_seen", 64'(got), 64'd1);
    if (got) begin
      checkOutput("scrub_dbg_gnt_cycle", 64'(g), 64'(s + 1 + DEPTH + 100));
      pushDbg('0, g + 2);
    end
    tick();
    idleInputs();
    tick(); tick(); tick();
    @(negedge aclk);
    checkOutput("scrub_busy_after", 64'(scrub_busy), 64'd0);
    for (int a = 0; a < DEPTH; a++) begin
      ctlRead(AW'(a), '0);
      tick();
    end
    idleInputs();
    tick(); tick();

    // Scrub start together with a debug read, then reset at address 0x300.
    dbgRead(11'h010, 1'b1);
    m = cyc;
    @(negedge aclk);
    checkOutput("start_dbg_gnt", 64'(bus.dbg_gnt), 64'd1);
    checkOutput("start_busy", 64'(scrub_busy), 64'd0);
    pushDbg('0, m + 2);
    tick();
    idleInputs();
    for (int i = 0; i < 11'h2FF; i++) tick();
    @(negedge aclk);
    checkOutput("scrub_addr_2ff", 64'(bus.ram_addr), 64'h2FF);
    tick();
    areset = 1'b1;
    bus.ctl_ce_n = 1'b0;
    @(negedge aclk);
    checkOutput("mid_rst_ram_en", 64'(bus.ram_en), 64'd0);
    tick();
    areset = 1'b0;
    idleInputs();
    @(negedge aclk);
    checkOutput("mid_rst_busy", 64'(scrub_busy), 64'd0);
    tick();

    // Debug read cut off by reset must never return.
    dbgRead(11'h011, 1'b0);
    @(negedge aclk);
    checkOutput("inflight_gnt", 64'(bus.dbg_gnt), 64'd1);
    tick();
    areset = 1'b1;
    idleInputs();
    @(negedge aclk);
    checkOutput("inflight_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    tick();
    areset = 1'b0;
    tick(); tick(); tick();

    // Fresh scrub restarts from address zero.
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    n = cyc;
    done_q.push_back(n + 1 + DEPTH);
    tick();
    idleInputs();
    @(negedge aclk);
    checkOutput("restart_addr", 64'(bus.ram_addr), 64'd0);
    checkOutput("restart_en", 64'(bus.ram_en), 64'd1);
    checkOutput("restart_busy", 64'(scrub_busy), 64'd1);
    for (int i = 0; i < DEPTH + 3; i++) tick();
    @(negedge aclk);

    checkOutput("dbg_q_left", 64'(dbg_q.size()), 64'd0);
    checkOutput("ctl_q_left", 64'(ctl_q.size()), 64'd0);
    checkOutput("done_q_left", 64'(done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
